// File: rtl/ycbcr_block_buffer_if.sv
// Pixel-in / sample-out bundle between the colour converter, the block buffer and the DCT.
// The master side feeds pixels and accepts samples; the slave side is the buffer itself.
interface ycbcr_block_buffer_if #(
    parameter int COMP_W = 8
);
    logic                  enable;
    logic [3*COMP_W-1:0]   data_in;
    logic [3*COMP_W-1:0]   data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  block_start;
    logic                  block_end;
    logic                  overflow;

    modport master (
        output enable, data_in, out_ready,
        input  data_out, out_valid, block_start, block_end, overflow
    );

    modport slave (
        input  enable, data_in, out_ready,
        output data_out, out_valid, block_start, block_end, overflow
    );
endinterface

// File: rtl/ycbcr_block_buffer.sv
// Ping-pong 8x8 block buffer between the YCbCr converter and the DCT.
// Optional feature: define LEVEL_SHIFT_EN to emit each component as (x-128) in two's complement.
module ycbcr_block_buffer #(
    parameter int COMP_W    = 8,
    parameter int OUT_ORDER = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ycbcr_block_buffer_if.slave    bus
);
    localparam int DW = 3 * COMP_W;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [DW-1:0]   bank [2][64];
    logic [1:0]      full;
    logic            wr_bank;
    logic            rd_bank;
    logic [5:0]      wr_idx;
    logic [5:0]      rd_idx;
    logic [5:0]      next_rd_idx;
    logic            write_ok;

    logic [DW-1:0]   data_out_q;
    logic            out_valid_q;
    logic            block_start_q;
    logic            block_end_q;
    logic            overflow_q;

    function automatic logic [5:0] addr_map(input logic [5:0] i);
        if (OUT_ORDER == 1)
            return {i[2:0], i[5:3]};
        else
            return i;
    endfunction

    // Storage stays unshifted; the shift is applied only on the way out.
    function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = x;
`ifdef LEVEL_SHIFT_EN
        for (int c = 0; c < 3; c++)
            y[c*COMP_W + COMP_W - 1] = ~x[c*COMP_W + COMP_W - 1];
`endif
        return y;
    endfunction

    assign write_ok    = bus.enable && !full[wr_bank];
    assign next_rd_idx = rd_idx + 6'd1;

    always_ff @(posedge clk) begin
        if (write_ok)
            bank[wr_bank][wr_idx] <= bus.data_in;
    end

    // A bank is only written while its full flag is clear and only cleared while it is set,
    // so the write-side set and the read-side clear never target the same bank on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            full          <= 2'b00;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_idx        <= 6'd0;
            rd_idx        <= 6'd0;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            block_start_q <= 1'b0;
            block_end_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (bus.enable) begin
                if (!full[wr_bank]) begin
                    wr_idx <= wr_idx + 6'd1;
                    if (wr_idx == 6'd63) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                    end
                end else begin
                    overflow_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        data_out_q    <= out_fmt(bank[rd_bank][addr_map(6'd0)]);
                        out_valid_q   <= 1'b1;
                        block_start_q <= 1'b1;
                        block_end_q   <= 1'b0;
                        rd_idx        <= 6'd0;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (rd_idx != 6'd63) begin
                            rd_idx        <= next_rd_idx;
                            data_out_q    <= out_fmt(bank[rd_bank][addr_map(next_rd_idx)]);
                            block_start_q <= 1'b0;
                            block_end_q   <= (next_rd_idx == 6'd63);
                        end else begin
                            full[rd_bank] <= 1'b0;
                            rd_bank       <= ~rd_bank;
                            rd_idx        <= 6'd0;
                            out_valid_q   <= 1'b0;
                            block_end_q   <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.block_start = block_start_q;
    assign bus.block_end   = block_end_q;
    assign bus.overflow    = overflow_q;
endmodule
